// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and redirect controller for a five-stage in-order pipeline.
//
// Decides, every cycle, which pipeline registers advance (pc, fetch/decode, decode/exec,
// exec/mem, mem/wb), which are flushed, and where the next PC comes from. Handles dcache
// stalls, load-use bubbles, icache misses, branch redirects that must wait for the icache,
// and the halt sequence (drain dcache writeback, then park in HALT until reset).
// All outputs are combinational from the state register and the current inputs.
//
// Ports
//   CLK, nRST        rising-edge clock, asynchronous active-low reset
//   ihit             icache returned the fetch this cycle
//   dmem_req, dhit   mem stage holds a load/store; dcache finished it
//   exec_memread     instruction in exec is a load
//   exec_rd          its destination register
//   decode_rs/_rt    source registers of the instruction in decode
//   redir_en         branch unit requests a redirect to redir_pc
//   redir_squash     redirect resolved in exec: decode holds a wrong-path instruction
//   halt_wb          halt instruction reached writeback
//   flush_done       dcache writeback after halt has completed
//   pc_en, npc_sel   PC register enable; select npc instead of the sequential PC
//   npc              redirect target (redir_pc in RUN, pending target in REDIR, else 0)
//   fd_en/fd_flush   fetch/decode register enable and flush
//   de_en/de_flush   decode/exec register enable and flush
//   em_en, mw_en     exec/mem and mem/wb register enables
//   halt             processor halted
//   stall_cycles     (PIPELINE_CTRL_PERF_CNT_EN) cycles with pc_en low in RUN/REDIR
//   flush_count      (PIPELINE_CTRL_PERF_CNT_EN) cycles with any flush asserted
//
// Build option: define PIPELINE_CTRL_PERF_CNT_EN to add the two performance counters.

module pipeline_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dmem_req,
  input  logic        dhit,
  input  logic        exec_memread,
  input  logic [4:0]  exec_rd,
  input  logic [4:0]  decode_rs,
  input  logic [4:0]  decode_rt,
  input  logic        redir_en,
  input  logic [31:0] redir_pc,
  input  logic        redir_squash,
  input  logic        halt_wb,
  input  logic        flush_done,
  output logic        pc_en,
  output logic        npc_sel,
  output logic [31:0] npc,
  output logic        fd_en,
  output logic        fd_flush,
  output logic        de_en,
  output logic        de_flush,
  output logic        em_en,
  output logic        mw_en,
  output logic        halt
`ifdef PIPELINE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic [1:0] {StRun, StRedir, StDrain, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  logic mem_stall;
  logic load_use;
  logic take_redir;
  logic squash_redir;

  assign mem_stall = dmem_req & ~dhit;
  assign load_use  = exec_memread & (exec_rd != 5'd0) &
                     ((exec_rd == decode_rs) | (exec_rd == decode_rt));

  // A decode-sourced redirect (no squash) yields to a load-use bubble: the branch in decode
  // will be re-evaluated next cycle. An exec-sourced redirect kills decode, so it wins.
  assign take_redir   = redir_en & (redir_squash | ~load_use);
  assign squash_redir = redir_en & redir_squash;

  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    pc_en     = 1'b0;
    npc_sel   = 1'b0;
    npc       = 32'd0;
    fd_en     = 1'b0;
    fd_flush  = 1'b0;
    de_en     = 1'b0;
    de_flush  = 1'b0;
    em_en     = 1'b0;
    mw_en     = 1'b0;
    halt      = 1'b0;

    unique case (state_q)
      StRun: begin
        npc = redir_pc;
        if (halt_wb) begin
          state_d = StDrain;
        end else if (mem_stall) begin
          // Whole pipe frozen; a pending redirect sits in frozen exec and comes back.
        end else if (take_redir) begin
          fd_en    = 1'b1;
          fd_flush = 1'b1;
          de_en    = 1'b1;
          de_flush = redir_squash;
          em_en    = 1'b1;
          mw_en    = 1'b1;
          if (ihit) begin
            pc_en   = 1'b1;
            npc_sel = 1'b1;
          end else begin
            // Fetch is busy with the wrong-path line; remember the target until it returns.
            pend_pc_d = redir_pc;
            state_d   = StRedir;
          end
        end else if (load_use) begin
          // Hold pc and fetch/decode, inject one bubble into exec.
          de_en    = 1'b1;
          de_flush = 1'b1;
          em_en    = 1'b1;
          mw_en    = 1'b1;
        end else if (!ihit) begin
          fd_en    = 1'b1;
          fd_flush = 1'b1;
          de_en    = 1'b1;
          em_en    = 1'b1;
          mw_en    = 1'b1;
        end else begin
          pc_en = 1'b1;
          fd_en = 1'b1;
          de_en = 1'b1;
          em_en = 1'b1;
          mw_en = 1'b1;
        end
      end

      StRedir: begin
        npc = pend_pc_q;
        if (mem_stall) begin
          // Frozen, pending target kept.
        end else begin
          fd_en    = 1'b1;
          fd_flush = 1'b1;
          de_en    = 1'b1;
          em_en    = 1'b1;
          mw_en    = 1'b1;
          if (squash_redir) begin
            // A younger exec redirect supersedes the pending one.
            pend_pc_d = redir_pc;
            de_flush  = 1'b1;
          end else if (ihit) begin
            // The returned word is from the old path: drop it and load the target.
            pc_en   = 1'b1;
            npc_sel = 1'b1;
            state_d = StRun;
          end
        end
      end

      StDrain: begin
        if (flush_done) begin
          state_d = StHalt;
        end
      end

      StHalt: begin
        halt = 1'b1;
      end

      default: begin
        state_d = StRun;
      end
    endcase

    // Outputs are quiet for as long as reset is held, not only after the next edge.
    if (!nRST) begin
      pc_en    = 1'b0;
      npc_sel  = 1'b0;
      npc      = 32'd0;
      fd_en    = 1'b0;
      fd_flush = 1'b0;
      de_en    = 1'b0;
      de_flush = 1'b0;
      em_en    = 1'b0;
      mw_en    = 1'b0;
      halt     = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= StRun;
      pend_pc_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;
  logic        fetch_state;

  assign fetch_state = (state_q == StRun) || (state_q == StRedir);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (fetch_state && !pc_en) begin
        stall_q <= stall_q + 32'd1;
      end
      if (fd_flush || de_flush) begin
        flush_q <= flush_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule
